cpu_evolution_mem_copy_master: RTL and testbench
================================================

Name: cpu_evolution_mem_copy_master

Overview:
- Avalon-MM master that drives the 1024x32 single-port on-chip RAM slave (s1) from the initiator side.
- Copies a block of words from src to dst, or fills a block with a constant pattern, under a start/done handshake from CPU-side control logic.
- Sits between a control register block and the on-chip memory slave port.
- Uses the slave's fixed read timing: address registered at the clock edge, readdata valid during the following cycle.

Parameters:
- ADDR_W, 10, word address width; memory depth is 2**ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; sampled with start.
- src_addr  in  ADDR_W  first source word address (copy only).
- dst_addr  in  ADDR_W  first destination word address.
- length  in  ADDR_W+1  word count, 0..1024.
- pattern  in  DATA_W  fill value (fill only).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- words_done  out  ADDR_W+1  words written so far in the current or last operation.
- m_address  out  ADDR_W  slave address.
- m_byteenable  out  DATA_W/8  always all ones.
- m_chipselect  out  1  slave select.
- m_write  out  1  write strobe.
- m_writedata  out  DATA_W  write data.
- m_clken  out  1  slave clock enable; tied to 1.
- m_readdata  in  DATA_W  slave read data.

Behaviour:
- Reset values (asynchronous): state IDLE; busy, done, m_chipselect, m_write = 0; m_address, m_writedata, words_done = 0; m_byteenable = all ones; m_clken = 1.
- All bus outputs are registered.
- States: IDLE, RD, CAP, WR, FILL, DONE.
- IDLE:
  - When start=1, latch mode, src, dst, length and pattern; clear words_done.
  - If length=0, go to DONE.
  - Otherwise go to RD (mode 0) or FILL (mode 1).
- RD: chipselect=1, write=0, address = src+i.
- CAP: chipselect=0; latch m_readdata into the data register.
- WR: chipselect=1, write=1, address = dst+i, writedata = latched data.
  - Increment i and words_done.
  - Next state is DONE if i+1 == length, else RD.
- FILL: chipselect=1, write=1, address = dst+i, writedata = pattern.
  - Increment i and words_done each cycle.
  - Go to DONE when i+1 == length.
- DONE: done=1 for exactly one cycle, busy still 1, all strobes 0; next state IDLE.
- Timing: with start sampled at edge k, the first bus cycle is k+1.
  - Copy: 3 cycles per word; done is high in cycle k+1+3N.
  - Fill: 1 cycle per word; done is high in cycle k+1+N.
  - length=0: done is high in cycle k+1 with no bus activity.
- Address arithmetic is modulo 2**ADDR_W: src+i and dst+i wrap from 1023 to 0 with no error.
- Overlapping ranges: words are copied strictly in ascending i order, one word read then written. The result is defined as that sequential order, so dst>src with overlap propagates data.
- start while busy is ignored, with no queuing.
- start and done never coincide, because start is sampled only in IDLE.
- length > 1024 cannot be encoded.
- Reset asserted mid-operation: immediate return to reset values. A write in progress at that edge is not guaranteed to complete.
- m_chipselect=0 and m_write=0 in IDLE, CAP and DONE.

Decomposition:
- Shared package cpu_evolution_mem_pkg holds:
  - the state enum (IDLE, RD, CAP, WR, FILL, DONE);
  - ADDR_W=10 and DATA_W=32 constants;
  - BE_ALL constant;
  - MODE_COPY and MODE_FILL constants.
- No sub-module: the FSM, index counter and address adders fit in one module.

Test Plan:
- Fill: mode=1, dst=0x010, length=4, pattern=0xDEADBEEF.
  - Writes appear at 0x010..0x013 on 4 consecutive cycles.
  - done is high 5 cycles after start; words_done=4; memory readback matches.
- Copy: preload 0x000..0x002 with 0x11111111, 0x22222222, 0x33333333; mode=0, src=0x000, dst=0x100, length=3.
  - 0x100..0x102 hold those values.
  - done is high in cycle k+10; the bus shows an RD/CAP/WR pattern per word.
- Wrap: copy with src=0x3FE, dst=0x3FF, length=3, source preloaded with A, B, C at 0x3FE, 0x3FF, 0x000.
  - Addresses wrap to 0x000 and 0x001.
  - Final contents: 0x3FF=A, 0x000=A, 0x001=A (forward overlap propagation).
- Zero length: start with length=0.
  - done is high the next cycle; m_chipselect never asserts; words_done=0.
- start while busy: a second start pulse mid-copy with different dst is ignored; only the first operation's writes occur.
- Reset mid-operation: assert reset during a 16-word fill after 5 writes.
  - All outputs take reset values asynchronously.
  - After release, the FSM is in IDLE with busy=0.
  - A new start with length=2 completes normally.

Source files
------------

// File: rtl/cpu_evolution_mem_pkg.sv
// Shared constants and state encoding for the on-chip RAM copy/fill master.
package cpu_evolution_mem_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [BE_W-1:0] BE_ALL    = '1;
  localparam logic            MODE_COPY = 1'b0;
  localparam logic            MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_evolution_mem_copy_master.sv
// Avalon-MM master that copies or fills a block of words in the 1024x32
// on-chip RAM, using the slave's one-cycle registered read latency.
module cpu_evolution_mem_copy_master #(
  parameter int unsigned ADDR_W = cpu_evolution_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_evolution_mem_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W:0]       length,
  input  logic [DATA_W-1:0]     pattern,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       words_done,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata
);

  import cpu_evolution_mem_pkg::*;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                done_q, done_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [ADDR_W:0]     idx_inc;
  logic                last_word;

  assign idx_inc   = idx_q + 1'b1;
  assign last_word = (idx_inc == len_q);

  // Bus outputs are computed for the state being entered, so every strobe
  // and address is a flop that lines up with state_q.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    cs_d    = 1'b0;
    wr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          pat_d   = pattern;
          idx_d   = '0;
          words_d = '0;
          if (length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (mode == MODE_COPY) begin
            state_d = S_RD;
            cs_d    = 1'b1;
            addr_d  = src_addr;
          end else begin
            state_d = S_FILL;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = dst_addr;
            wdata_d = pattern;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        // Read data is valid in this cycle; it becomes the write data directly.
        state_d = S_WR;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = dst_q + idx_q[ADDR_W-1:0];
        wdata_d = m_readdata;
      end
      S_WR: begin
        idx_d   = idx_inc;
        words_d = words_q + 1'b1;
        if (last_word) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD;
          cs_d    = 1'b1;
          addr_d  = src_q + idx_inc[ADDR_W-1:0];
        end
      end
      S_FILL: begin
        idx_d   = idx_inc;
        words_d = words_q + 1'b1;
        if (last_word) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = dst_q + idx_inc[ADDR_W-1:0];
          wdata_d = pat_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign words_done   = words_q;
  assign m_address    = addr_q;
  assign m_byteenable = '1;
  assign m_chipselect = cs_q;
  assign m_write      = wr_q;
  assign m_writedata  = wdata_q;
  assign m_clken      = 1'b1;

  logic unused_mode;
  assign unused_mode = mode_q;

endmodule

// File: tb/tb_cpu_evolution_mem_copy_master.sv
// Self-checking bench: RAM slave model plus a sequential copy/fill reference.
module tb_cpu_evolution_mem_copy_master;
  import cpu_evolution_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mode;
  logic [9:0]  src_addr, dst_addr;
  logic [10:0] length;
  logic [31:0] pattern;
  logic        busy, done, m_chipselect, m_write, m_clken;
  logic [10:0] words_done;
  logic [9:0]  m_address;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata, m_readdata;

  cpu_evolution_mem_copy_master #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .pattern(pattern),
    .busy(busy), .done(done), .words_done(words_done),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken),
    .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // RAM slave: address registered at the edge, readdata valid the next cycle.
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pre_we = 1'b0, clr = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'(i) ^ 32'hA5A5_0000;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (m_clken && m_chipselect && m_write) begin
      mem[m_address] <= m_writedata;
    end
    if (m_clken) m_readdata <= mem[m_address];
  end

  typedef struct {
    int          cyc;
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } evt_t;

  evt_t obs_q[$];
  evt_t exp_q[$];
  int   exp_done;
  int   done_cyc;
  logic [10:0] wd_at_done;
  logic busy_at_done, busy_after, done_after;
  int   checks = 0;
  int   failures = 0;

  task automatic clear_mem();
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i) ^ 32'hA5A5_0000;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1 pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Reference: sequential word-at-a-time semantics with modulo-1024 addresses.
  task automatic model_op(input bit md, input int s, input int d, input int n, input logic [31:0] p);
    evt_t e;
    logic [31:0] v;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (md) begin
        e.cyc = i + 1; e.wr = 1'b1; e.addr = 10'((d + i) % 1024); e.data = p;
        ref_mem[(d + i) % 1024] = p;
        exp_q.push_back(e);
      end else begin
        v = ref_mem[(s + i) % 1024];
        e.cyc = 3 * i + 1; e.wr = 1'b0; e.addr = 10'((s + i) % 1024); e.data = '0;
        exp_q.push_back(e);
        ref_mem[(d + i) % 1024] = v;
        e.cyc = 3 * i + 3; e.wr = 1'b1; e.addr = 10'((d + i) % 1024); e.data = v;
        exp_q.push_back(e);
      end
    end
    exp_done = (n == 0) ? 1 : (md ? n + 1 : 3 * n + 1);
  endtask

  // Drive one request and record every selected bus cycle until done.
  task automatic run_op(input bit md, input logic [9:0] s, input logic [9:0] d,
                        input logic [10:0] n, input logic [31:0] p,
                        input int extra_cyc, input logic [9:0] alt_dst);
    evt_t e;
    obs_q.delete();
    done_cyc = -1;
    wd_at_done = 'x; busy_at_done = 1'bx;
    @(negedge clk);
    mode = md; src_addr = s; dst_addr = d; length = n; pattern = p; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 4000; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (extra_cyc != 0 && c == extra_cyc) begin start = 1'b1; dst_addr = alt_dst; mode = ~md; end
      else if (extra_cyc != 0 && c == extra_cyc + 1) begin start = 1'b0; dst_addr = d; mode = md; end
      if (m_chipselect === 1'b1) begin
        e.cyc = c; e.wr = m_write; e.addr = m_address; e.data = m_writedata;
        obs_q.push_back(e);
      end
      if (done === 1'b1) begin
        done_cyc = c; wd_at_done = words_done; busy_at_done = busy;
        break;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    busy_after = busy; done_after = done;
  endtask

  function automatic int evt_diffs();
    int n = 0;
    int m;
    if (obs_q.size() != exp_q.size()) n++;
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].wr !== exp_q[i].wr ||
          obs_q[i].addr !== exp_q[i].addr || (exp_q[i].wr && obs_q[i].data !== exp_q[i].data)) n++;
    return n;
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; pattern = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, m_chipselect, m_write} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {busy, done, m_chipselect, m_write});
    end
    checks++;
    if (m_address !== 10'd0 || m_writedata !== 32'd0 || words_done !== 11'd0) begin
      failures++; $display("FAIL reset_values addr=%h wdata=%h words=%0d exp=0", m_address, m_writedata, words_done);
    end
    checks++;
    if (m_byteenable !== BE_ALL || m_clken !== 1'b1) begin
      failures++; $display("FAIL reset_be_clken be=%b clken=%b exp=1111/1", m_byteenable, m_clken);
    end
    @(negedge clk); reset = 1'b0;
    clear_mem();
  endtask

  task automatic test_fill();
    model_op(1'b1, 0, 'h010, 4, 32'hDEAD_BEEF);
    run_op(1'b1, 10'h000, 10'h010, 11'd4, 32'hDEAD_BEEF, 0, 10'h000);
    checks++;
    if (done_cyc != 5) begin failures++; $display("FAIL fill_done_cycle got=%0d exp=5", done_cyc); end
    checks++;
    if (wd_at_done !== 11'd4 || busy_at_done !== 1'b1) begin
      failures++; $display("FAIL fill_words got=%0d busy=%b exp=4/1", wd_at_done, busy_at_done);
    end
    checks++;
    if (evt_diffs() != 0) begin failures++; $display("FAIL fill_bus got=%0d diffs exp=0", evt_diffs()); end
    checks++;
    if (mem_diffs() != 0) begin failures++; $display("FAIL fill_mem got=%0d diffs exp=0", mem_diffs()); end
    checks++;
    if (busy_after !== 1'b0 || done_after !== 1'b0) begin
      failures++; $display("FAIL fill_after busy=%b done=%b exp=0/0", busy_after, done_after);
    end
  endtask

  task automatic test_copy();
    preload(10'h000, 32'h1111_1111);
    preload(10'h001, 32'h2222_2222);
    preload(10'h002, 32'h3333_3333);
    model_op(1'b0, 'h000, 'h100, 3, '0);
    run_op(1'b0, 10'h000, 10'h100, 11'd3, 32'h0, 0, 10'h000);
    checks++;
    if (done_cyc != 10) begin failures++; $display("FAIL copy_done_cycle got=%0d exp=10", done_cyc); end
    checks++;
    if (evt_diffs() != 0) begin failures++; $display("FAIL copy_bus got=%0d diffs exp=0", evt_diffs()); end
    checks++;
    if (mem[10'h101] !== 32'h2222_2222 || mem_diffs() != 0) begin
      failures++; $display("FAIL copy_mem got=%h diffs=%0d exp=22222222/0", mem[10'h101], mem_diffs());
    end
  endtask

  task automatic test_wrap();
    preload(10'h3FE, 32'hAAAA_0001);
    preload(10'h3FF, 32'hBBBB_0002);
    preload(10'h000, 32'hCCCC_0003);
    model_op(1'b0, 'h3FE, 'h3FF, 3, '0);
    run_op(1'b0, 10'h3FE, 10'h3FF, 11'd3, 32'h0, 0, 10'h000);
    checks++;
    if (evt_diffs() != 0) begin failures++; $display("FAIL wrap_bus got=%0d diffs exp=0", evt_diffs()); end
    checks++;
    if (mem[10'h3FF] !== 32'hAAAA_0001 || mem[10'h000] !== 32'hAAAA_0001 || mem[10'h001] !== 32'hAAAA_0001) begin
      failures++; $display("FAIL wrap_mem got=%h,%h,%h exp=aaaa0001 x3", mem[10'h3FF], mem[10'h000], mem[10'h001]);
    end
    checks++;
    if (wd_at_done !== 11'd3) begin failures++; $display("FAIL wrap_words got=%0d exp=3", wd_at_done); end
  endtask

  task automatic test_zero_length();
    model_op(1'b0, 5, 9, 0, '0);
    run_op(1'b0, 10'h005, 10'h009, 11'd0, 32'h0, 0, 10'h000);
    checks++;
    if (done_cyc != 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
    checks++;
    if (obs_q.size() != 0 || wd_at_done !== 11'd0) begin
      failures++; $display("FAIL zero_activity got=%0d cycles words=%0d exp=0/0", obs_q.size(), wd_at_done);
    end
  endtask

  task automatic test_start_while_busy();
    model_op(1'b0, 'h020, 'h180, 4, '0);
    run_op(1'b0, 10'h020, 10'h180, 11'd4, 32'h0, 5, 10'h280);
    checks++;
    if (done_cyc != 13) begin failures++; $display("FAIL busy_done_cycle got=%0d exp=13", done_cyc); end
    checks++;
    if (evt_diffs() != 0 || mem_diffs() != 0) begin
      failures++; $display("FAIL busy_ignored got=%0d bus %0d mem diffs exp=0/0", evt_diffs(), mem_diffs());
    end
    checks++;
    if (busy_after !== 1'b0) begin failures++; $display("FAIL busy_requeued got=%b exp=0", busy_after); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    int writes;
    p = $urandom;
    writes = 0;
    @(negedge clk);
    mode = 1'b1; dst_addr = 10'h040; length = 11'd16; pattern = p; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (m_chipselect === 1'b1 && m_write === 1'b1) writes++;
      if (writes == 6) break;
    end
    checks++;
    if (writes != 6) begin failures++; $display("FAIL rstmid_progress got=%0d exp=6", writes); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, m_chipselect, m_write} !== 4'b0000 || m_address !== 10'd0 ||
        m_writedata !== 32'd0 || words_done !== 11'd0) begin
      failures++; $display("FAIL rstmid_async got=%b addr=%h wdata=%h words=%0d exp=0",
                           {busy, done, m_chipselect, m_write}, m_address, m_writedata, words_done);
    end
    for (int i = 0; i < 5; i++) ref_mem[10'h040 + i] = p;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || m_chipselect !== 1'b0) begin
      failures++; $display("FAIL rstmid_idle busy=%b cs=%b exp=0/0", busy, m_chipselect);
    end
    checks++;
    if (mem_diffs() != 0) begin failures++; $display("FAIL rstmid_mem got=%0d diffs exp=0", mem_diffs()); end
    model_op(1'b1, 0, 'h300, 2, 32'h0BAD_F00D);
    run_op(1'b1, 10'h000, 10'h300, 11'd2, 32'h0BAD_F00D, 0, 10'h000);
    checks++;
    if (done_cyc != 3 || evt_diffs() != 0 || mem_diffs() != 0) begin
      failures++; $display("FAIL rstmid_restart done=%0d bus=%0d mem=%0d exp=3/0/0", done_cyc, evt_diffs(), mem_diffs());
    end
  endtask

  task automatic test_random();
    bit md;
    int s, d, n;
    logic [31:0] p;
    for (int k = 0; k < 18; k++) begin
      md = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 1023);
      d = $urandom_range(0, 1023);
      n = $urandom_range(0, 24);
      p = $urandom;
      if (k == 16) begin md = 1'b1; n = 1024; end
      if (k == 17) begin md = 1'b0; n = 1024; end
      model_op(md, s, d, n, p);
      run_op(md, 10'(s), 10'(d), 11'(n), p, 0, 10'h000);
      checks++;
      if (done_cyc != exp_done || wd_at_done !== 11'(n)) begin
        failures++; $display("FAIL rand%0d_done cyc=%0d words=%0d exp=%0d/%0d", k, done_cyc, wd_at_done, exp_done, n);
      end
      checks++;
      if (evt_diffs() != 0 || mem_diffs() != 0) begin
        failures++; $display("FAIL rand%0d_data bus=%0d mem=%0d diffs exp=0/0", k, evt_diffs(), mem_diffs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
